// File: rtl/dual_rail_pkg.sv
// Shared types and constants for the dual-rail inject controller and its helpers.
//   enc_e        : handshake encoding of the asynchronous link (two-phase or four-phase)
//   inj_state_e  : sequencer states
//   SYNC_STAGES  : depth of the acknowledge synchroniser
//   enc_from_str : maps the ENC string parameter onto enc_e
package dual_rail_pkg;

  typedef enum logic {
    ENC_TP,
    ENC_4P
  } enc_e;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    SPACER,
    ERR
  } inj_state_e;

  localparam int unsigned SYNC_STAGES = 2;

  // Anything other than "TP" selects four-phase level signalling.
  function automatic enc_e enc_from_str(input string enc);
    return (enc == "TP") ? ENC_TP : ENC_4P;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchroniser with asynchronous active-low reset.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, loads ResetVal into every stage
//   d_i    : asynchronous input
//   q_o    : synchronised output, Stages cycles behind d_i
module sync_2ff #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/dual_rail_inject_ctrl.sv
// Sequencer that pushes words from a synchronous valid/ready source into a dual-rail
// value-inject stage, running one token (DATA) / return (SPACER) handshake per word.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   s_valid_i    : source word valid
//   s_ready_o    : controller can accept a word (registered)
//   s_data_i     : source word
//   ack_async_i  : link acknowledge, asynchronous to clk_i
//   clr_err_i    : clears the sticky error and returns from ERR to IDLE
//   inj_en_o     : inject stage enable
//   inj_data_o   : inject stage data
//   busy_o       : high in any state other than IDLE
//   err_o        : sticky acknowledge-timeout flag
//   inj_count_o  : number of completed injections (wraps)
module dual_rail_inject_ctrl
  import dual_rail_pkg::*;
#(
  parameter string       ENC     = "TP",
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             ack_async_i,
  input  logic             clr_err_i,
  output logic             inj_en_o,
  output logic [WIDTH-1:0] inj_data_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] inj_count_o
);

  localparam enc_e            EncMode = enc_from_str(ENC);
  localparam int unsigned     TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  inj_state_e       state_q;
  logic             inj_en_q;
  logic [WIDTH-1:0] inj_data_q;
  logic             s_ready_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_prev_q;
  logic [TmoW-1:0]  tmo_q;

  logic ack_s;
  logic ack_ev;
  logic tmo_hit;

  sync_2ff #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b0)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (ack_async_i),
    .q_o   (ack_s)
  );

  // Two-phase: any change versus the last consumed level. Four-phase: the level the
  // current phase is waiting for.
  always_comb begin
    ack_ev = 1'b0;
    if (EncMode == ENC_TP) begin
      ack_ev = ack_s ^ ack_prev_q;
    end else if (state_q == DATA) begin
      ack_ev = ack_s;
    end else if (state_q == SPACER) begin
      ack_ev = ~ack_s;
    end
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TmoLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      inj_en_q   <= 1'b0;
      inj_data_q <= '0;
      s_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ack_prev_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          s_ready_q  <= 1'b1;
          tmo_q      <= '0;
          // Track the link so an acknowledge seen while idle is never counted later.
          ack_prev_q <= ack_s;
          if (s_valid_i && s_ready_q) begin
            inj_data_q <= s_data_i;
            inj_en_q   <= 1'b1;
            s_ready_q  <= 1'b0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          s_ready_q <= 1'b0;
          // Acknowledge takes priority over a timeout in the same cycle.
          if (ack_ev) begin
            ack_prev_q <= ack_s;
            inj_en_q   <= 1'b0;
            tmo_q      <= '0;
            state_q    <= SPACER;
          end else if (tmo_hit) begin
            inj_en_q <= 1'b0;
            err_q    <= 1'b1;
            tmo_q    <= '0;
            state_q  <= ERR;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        SPACER: begin
          s_ready_q <= 1'b0;
          inj_en_q  <= 1'b0;
          if (ack_ev) begin
            ack_prev_q <= ack_s;
            inj_data_q <= '0;
            cnt_q      <= cnt_q + CNT_W'(1);
            tmo_q      <= '0;
            state_q    <= IDLE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= ERR;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        ERR: begin
          s_ready_q <= 1'b0;
          inj_en_q  <= 1'b0;
          tmo_q     <= '0;
          if (clr_err_i) begin
            err_q      <= 1'b0;
            inj_data_q <= '0;
            // Re-align the two-phase reference with whatever level the link now holds.
            ack_prev_q <= ack_s;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ready_o   = s_ready_q;
  assign inj_en_o    = inj_en_q;
  assign inj_data_o  = inj_data_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign inj_count_o = cnt_q;

endmodule
